// File: rtl/motor_pwm_rampa_pkg.sv
// Shared types and constants for the motor soft-start PWM stage.
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SUBIENDO = 2'd1,
    ESTABLE  = 2'd2,
    BAJANDO  = 2'd3
  } estado_pwm_t;

  localparam logic [6:0] DUTY_30  = 7'd30;
  localparam logic [6:0] DUTY_50  = 7'd50;
  localparam logic [6:0] DUTY_100 = 7'd100;
  localparam logic [6:0] PWM_TOP  = 7'd99;

  // Position of the duty value relative to its target decides the state.
  function automatic estado_pwm_t clasifica(input logic [6:0] duty,
                                            input logic [6:0] target);
    if (duty == target) return (target == 7'd0) ? IDLE : ESTABLE;
    else if (duty < target) return SUBIENDO;
    else return BAJANDO;
  endfunction

endpackage

// File: rtl/motor_pwm_rampa_divisor_tick.sv
// Free-running clock divider: one-clock tick every DIV clocks, first tick DIV clocks after reset.
module divisor_tick #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TOP = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TOP);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/motor_pwm_rampa.sv
// Motor PWM stage: ramps duty toward the requested level and drives a shadowed 100-count PWM.
// Macro SOFT_RAMP_EN: defined = 1 %/tick ramp; undefined = duty jumps to target on the next ramp tick.
//
// state    | meaning
// IDLE     | duty = 0, target = 0
// SUBIENDO | duty below target, stepping up on ramp ticks
// ESTABLE  | duty = target > 0, holding
// BAJANDO  | duty above target, stepping down on ramp ticks
module motor_pwm_rampa
  import motor_pkg::*;
#(
  parameter int unsigned PRESCALE = 10,
  parameter int unsigned RAMP_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       out_30,
  input  logic       out_50,
  input  logic       out_100,
  output logic       pwm,
  output logic [6:0] duty,
  output logic       busy,
  output logic       fault
);

  logic        tick_pre, tick_rampa;
  logic [6:0]  target, duty_step;
  logic        ilegal;

  estado_pwm_t estado_q, estado_d;
  logic [6:0]  duty_q, duty_d;
  logic [6:0]  duty_sh_q, duty_sh_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        pwm_q, fault_q;

  divisor_tick #(.DIV(PRESCALE)) u_div_pre (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_pre)
  );

  divisor_tick #(.DIV(RAMP_DIV)) u_div_rampa (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_rampa)
  );

  always_comb begin
    target = 7'd0;
    ilegal = 1'b0;
    case ({out_100, out_50, out_30})
      3'b000:  target = 7'd0;
      3'b001:  target = DUTY_30;
      3'b010:  target = DUTY_50;
      3'b100:  target = DUTY_100;
      default: ilegal = 1'b1;
    endcase
  end

  always_comb begin
`ifdef SOFT_RAMP_EN
    duty_step = duty_q;
    if (duty_q < target && duty_q < DUTY_100) duty_step = duty_q + 7'd1;
    else if (duty_q > target && duty_q != 7'd0) duty_step = duty_q - 7'd1;
`else
    duty_step = target;
`endif
    duty_d   = tick_rampa ? duty_step : duty_q;
    // State follows the post-tick duty, so a target change never costs an extra tick.
    estado_d = clasifica(duty_d, target);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= IDLE;
      duty_q   <= 7'd0;
      fault_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      duty_q   <= duty_d;
      fault_q  <= ilegal;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    duty_sh_d = duty_sh_q;
    if (tick_pre) begin
      if (cnt_q == PWM_TOP) begin
        cnt_d     = 7'd0;
        duty_sh_d = duty_q;
      end else begin
        cnt_d = cnt_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= 7'd0;
      duty_sh_q <= 7'd0;
      pwm_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      duty_sh_q <= duty_sh_d;
      pwm_q     <= (cnt_q < duty_sh_q);
    end
  end

  assign pwm   = pwm_q;
  assign duty  = duty_q;
  assign busy  = (estado_q != IDLE) && (estado_q != ESTABLE);
  assign fault = fault_q;

endmodule

// File: tb/tb_motor_pwm_rampa.sv
// Directed bench for motor_pwm_rampa (PRESCALE=1, RAMP_DIV=4); expectations follow SOFT_RAMP_EN.
module tb_motor_pwm_rampa;

  logic       clk;
  logic       reset;
  logic       out_30, out_50, out_100;
  logic       pwm;
  logic [6:0] duty;
  logic       busy, fault;

  int total;
  int bad;
  int cyc;
  int hi_cnt [0:19];

  motor_pwm_rampa #(.PRESCALE(1), .RAMP_DIV(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .out_30  (out_30),
    .out_50  (out_50),
    .out_100 (out_100),
    .pwm     (pwm),
    .duty    (duty),
    .busy    (busy),
    .fault   (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic comprobar(input string tag, input int obs, input int exp_v);
    total++;
    if (obs != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  // One clock; cyc counts edges since reset release, pwm highs binned per 100 edges.
  task automatic paso();
    @(posedge clk);
    #1;
    cyc++;
    if (pwm) hi_cnt[(cyc - 1) / 100]++;
  endtask

  task automatic hasta(input int k);
    while (cyc < k) paso();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    for (int i = 0; i < 20; i++) hi_cnt[i] = 0;
    reset   = 1'b1;
    out_30  = 1'b1;
    out_50  = 1'b1;
    out_100 = 1'b1;
    #12;
    comprobar("rst_pwm",   int'(pwm),   0);
    comprobar("rst_duty",  int'(duty),  0);
    comprobar("rst_busy",  int'(busy),  0);
    comprobar("rst_fault", int'(fault), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    paso();
    comprobar("fault_after_rel", int'(fault), 1);
    comprobar("idle_busy",       int'(busy),  0);
    out_50  = 1'b0;
    out_100 = 1'b0;
    paso();
    comprobar("fault_clear", int'(fault), 0);
    comprobar("busy_rise",   int'(busy),  1);

`ifdef SOFT_RAMP_EN
    hasta(119); comprobar("up30_pre", int'(duty), 29); comprobar("up30_busy", int'(busy), 1);
    hasta(120); comprobar("up30_done", int'(duty), 30); comprobar("up30_est", int'(busy), 0);
`else
    hasta(3); comprobar("load30_pre", int'(duty), 0); comprobar("load30_busy", int'(busy), 1);
    hasta(4); comprobar("load30_done", int'(duty), 30); comprobar("load30_est", int'(busy), 0);
`endif

    hasta(300);
    out_30  = 1'b0;
    out_100 = 1'b1;
`ifdef SOFT_RAMP_EN
    hasta(301); comprobar("up100_busy", int'(busy), 1);
    hasta(579); comprobar("up100_pre", int'(duty), 99);
    hasta(580); comprobar("up100_done", int'(duty), 100); comprobar("up100_est", int'(busy), 0);
`else
    hasta(303); comprobar("load100_pre", int'(duty), 30); comprobar("load100_busy", int'(busy), 1);
    hasta(304); comprobar("load100_done", int'(duty), 100); comprobar("load100_est", int'(busy), 0);
`endif

    hasta(700);
    out_100 = 1'b0;
`ifdef SOFT_RAMP_EN
    hasta(1099); comprobar("down0_pre", int'(duty), 1); comprobar("down0_busy", int'(busy), 1);
    hasta(1100); comprobar("down0_done", int'(duty), 0); comprobar("down0_idle", int'(busy), 0);
`else
    hasta(703); comprobar("load0_pre", int'(duty), 100); comprobar("load0_busy", int'(busy), 1);
    hasta(704); comprobar("load0_done", int'(duty), 0); comprobar("load0_idle", int'(busy), 0);
`endif

    hasta(1300);
    comprobar("hi_p0_sh0",     hi_cnt[0], 0);
    comprobar("hi_p2_sh30",    hi_cnt[2], 30);
    comprobar("hi_p3_shadow",  hi_cnt[3], 30);
    comprobar("hi_p6_sh100",   hi_cnt[6], 100);
    comprobar("hi_p12_sh0",    hi_cnt[12], 0);
`ifdef SOFT_RAMP_EN
    comprobar("hi_p1_ramp",    hi_cnt[1], 24);
    comprobar("hi_p4_ramp",    hi_cnt[4], 54);
    comprobar("hi_p10_ramp",   hi_cnt[10], 26);
    comprobar("hi_p11_ramp",   hi_cnt[11], 1);
`else
    comprobar("hi_p1_load",    hi_cnt[1], 30);
    comprobar("hi_p4_load",    hi_cnt[4], 100);
    comprobar("hi_p10_load",   hi_cnt[10], 0);
    comprobar("hi_p11_load",   hi_cnt[11], 0);
`endif

    out_100 = 1'b1;
`ifdef SOFT_RAMP_EN
    hasta(1460); comprobar("mid_at40", int'(duty), 40);
    out_100 = 1'b0;
    out_50  = 1'b1;
    hasta(1500); comprobar("mid_to50", int'(duty), 50);
`else
    hasta(1460); comprobar("mid_at100", int'(duty), 100);
    out_100 = 1'b0;
    out_50  = 1'b1;
    hasta(1463); comprobar("mid_pre50", int'(duty), 100);
    hasta(1464); comprobar("mid_to50", int'(duty), 50);
`endif
    hasta(1540);
    comprobar("no_overshoot", int'(duty), 50);
    comprobar("hold50_busy",  int'(busy), 0);

    out_30 = 1'b1;
    paso();
    comprobar("fault_two_req", int'(fault), 1);
    comprobar("fault_busy",    int'(busy),  1);
    out_30 = 1'b0;
    paso();
    comprobar("fault_drop",   int'(fault), 0);
    comprobar("fault_settle", int'(busy),  0);
    hasta(1544);
    comprobar("fault_no_move", int'(duty), 50);

    out_50 = 1'b0;
`ifdef SOFT_RAMP_EN
    hasta(1676);
    comprobar("pre_rst_duty", int'(duty), 17);
    comprobar("pre_rst_busy", int'(busy), 1);
`else
    hasta(1545);
    comprobar("pre_rst_duty", int'(duty), 50);
    comprobar("pre_rst_busy", int'(busy), 1);
    comprobar("pre_rst_pwm",  int'(pwm),  1);
`endif
    #2;
    reset = 1'b1;
    #1;
    comprobar("async_duty",  int'(duty),  0);
    comprobar("async_busy",  int'(busy),  0);
    comprobar("async_pwm",   int'(pwm),   0);
    comprobar("async_fault", int'(fault), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
